io_bus_arbiter: RTL and testbench

Shares the single memory-mapped I/O bus (address bus, bidirectional data bus, write enable) between NREQ requesters such as the CPU memory stage and a DMA/debug port. Grants the bus round-robin, runs exactly one bus transaction per grant with a programmable number of hold cycles, captures read data, and signals completion. It is the only driver of the I/O bus address, write-enable and write data. Device modules only decode the address and respond.

---
 rtl/io_bus_pkg.sv | 22 ++
 rtl/io_bus_arbiter_if.sv | 30 +++
 rtl/rr_pick.sv | 35 +++
 rtl/io_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_io_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the I/O bus arbiter and the devices on its bus.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Idle address must decode to no device so a parked bus never hits a register.
  localparam logic [31:0] IDLE_ADDR_DEF = 32'h0000_0000;
  localparam logic [31:0] OUT_DEV_ADDR  = 32'hF000_0000;
  localparam logic [31:0] IN_DEV_ADDR   = 32'hF000_0004;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Requester handshake and bus address/enable bundle for io_bus_arbiter.
// Latency: none (wiring only).
// Backpressure: requesters hold req until done; no other flow control.
interface io_bus_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int DBITS = 32
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*DBITS-1:0] req_addr;
  logic [NREQ*DBITS-1:0] req_wdata;
  logic [NREQ-1:0]       lock;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [DBITS-1:0]      rdata;
  logic [DBITS-1:0]      abus;
  logic                  we;

  // The arbiter is the bus master: it owns abus/we and answers requesters.
  modport master (
    input  req, req_we, req_addr, req_wdata, lock,
    output gnt, done, rdata, abus, we
  );

  // Requesters and address-decoding devices sit on the other side.
  modport slave (
    output req, req_we, req_addr, req_wdata, lock,
    input  gnt, done, rdata, abus, we
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after last_gnt, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; any=0 when no requester is asserting.
module rr_pick
  import io_bus_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_bits(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_gnt,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  int cand;

  // Scan from last_gnt+1 around to last_gnt itself; the first hit wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_gnt) + k) % NREQ;
      if (!any && req[cand]) begin
        any          = 1'b1;
        win_idx      = IW'(cand);
        win_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin owner of the I/O bus; one transaction per grant, optional locked back-to-back (IOARB_LOCK_EN).
// Latency: req sampled to done pulse is WAIT_CYCLES+2 cycles; period WAIT_CYCLES+3 (WAIT_CYCLES+2 when locked).
// Backpressure: requesters hold req until done; req is only sampled in IDLE (and in DONE for a locked owner).
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int               NREQ        = 2,
  parameter int               DBITS       = 32,
  parameter int               WAIT_CYCLES = 0,
  parameter logic [DBITS-1:0] IDLE_ADDR   = DBITS'(IDLE_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  io_bus_arbiter_if.master  bus,
  // Kept as a plain port so tri-state resolution with the devices stays at the net level.
  inout  wire [DBITS-1:0]   dbus
);

  localparam int IW = idx_bits(NREQ);

  state_t            state, nxt_state;
  logic [3:0]        cnt, nxt_cnt;
  logic [NREQ-1:0]   gnt_q, nxt_gnt;
  logic [NREQ-1:0]   done_q, nxt_done;
  logic [DBITS-1:0]  rdata_q, nxt_rdata;
  logic [DBITS-1:0]  abus_q, nxt_abus;
  logic              we_q, nxt_we;
  logic [DBITS-1:0]  wdat_q, nxt_wdat;
  logic [IW-1:0]     last_gnt, nxt_last;
  logic [IW-1:0]     idx_q, nxt_idx;

  logic [NREQ-1:0]   pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [IW-1:0]     sel_idx;
  logic [DBITS-1:0]  sel_addr;
  logic [DBITS-1:0]  sel_wdata;
  logic              sel_we;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req      (bus.req),
    .last_gnt (last_gnt),
    .win_oh   (pick_oh),
    .win_idx  (pick_idx),
    .any      (pick_any)
  );

  // Fields come from the new winner in IDLE, or from the current owner when a lock re-arms in DONE.
  assign sel_idx   = (state == DONE) ? idx_q : pick_idx;
  assign sel_addr  = bus.req_addr[int'(sel_idx)*DBITS +: DBITS];
  assign sel_wdata = bus.req_wdata[int'(sel_idx)*DBITS +: DBITS];
  assign sel_we    = bus.req_we[sel_idx];

`ifndef IOARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^bus.lock;
`endif

  // State and all registered outputs; reset parks the bus regardless of the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      abus_q   <= IDLE_ADDR;
      we_q     <= 1'b0;
      wdat_q   <= '0;
      last_gnt <= IW'(NREQ - 1);
      idx_q    <= '0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      gnt_q    <= nxt_gnt;
      done_q   <= nxt_done;
      rdata_q  <= nxt_rdata;
      abus_q   <= nxt_abus;
      we_q     <= nxt_we;
      wdat_q   <= nxt_wdat;
      last_gnt <= nxt_last;
      idx_q    <= nxt_idx;
    end
  end

  // Next-state and next-output decode for the IDLE -> ACCESS -> DONE cycle.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_gnt   = gnt_q;
    nxt_done  = '0;
    nxt_rdata = rdata_q;
    nxt_abus  = abus_q;
    nxt_we    = we_q;
    nxt_wdat  = wdat_q;
    nxt_last  = last_gnt;
    nxt_idx   = idx_q;
    case (state)
      IDLE: begin
        if (pick_any) begin
          nxt_idx   = pick_idx;
          nxt_gnt   = pick_oh;
          nxt_abus  = sel_addr;
          nxt_we    = sel_we;
          nxt_wdat  = sel_wdata;
          nxt_cnt   = 4'(WAIT_CYCLES);
          nxt_state = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          // Commit edge: the device sees the write now, read data is sampled now.
          if (!we_q) nxt_rdata = dbus;
          nxt_done  = gnt_q;
          nxt_abus  = IDLE_ADDR;
          nxt_we    = 1'b0;
          nxt_state = DONE;
        end else begin
          nxt_cnt = cnt - 4'd1;
        end
      end
      DONE: begin
        nxt_last  = idx_q;
        nxt_gnt   = '0;
        nxt_state = IDLE;
`ifdef IOARB_LOCK_EN
        // A locked owner goes straight back to ACCESS so nobody can slip in between.
        if (bus.lock[idx_q] && bus.req[idx_q]) begin
          nxt_last  = last_gnt;
          nxt_gnt   = gnt_q;
          nxt_abus  = sel_addr;
          nxt_we    = sel_we;
          nxt_wdat  = sel_wdata;
          nxt_cnt   = 4'(WAIT_CYCLES);
          nxt_state = ACCESS;
        end
`endif
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.abus  = abus_q;
  assign bus.we    = we_q;
  // we_q is only ever set during ACCESS, so it doubles as the data-bus drive enable.
  assign dbus      = we_q ? wdat_q : {DBITS{1'bz}};

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: two instances (no wait / two wait cycles) with simple bus devices.
// Latency: n/a.
// Backpressure: n/a.
module tb_io_bus_arbiter;
  import io_bus_pkg::*;

  typedef struct {
    int          idx;
    bit          rd;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  io_bus_arbiter_if #(.NREQ(2), .DBITS(32)) ia();
  io_bus_arbiter_if #(.NREQ(2), .DBITS(32)) ib();
  wire [31:0] dbus_a;
  wire [31:0] dbus_b;

  io_bus_arbiter #(.NREQ(2), .DBITS(32), .WAIT_CYCLES(0), .IDLE_ADDR(IDLE_ADDR_DEF)) dut_a (
    .clk(clk), .reset(reset), .bus(ia), .dbus(dbus_a));
  io_bus_arbiter #(.NREQ(2), .DBITS(32), .WAIT_CYCLES(2), .IDLE_ADDR(IDLE_ADDR_DEF)) dut_b (
    .clk(clk), .reset(reset), .bus(ib), .dbus(dbus_b));

  // Output device on bus A: 10-bit register, readable back at the same address.
  logic [9:0] out_dev;
  always @(posedge clk or posedge reset) begin
    if (reset) out_dev <= '0;
    else if (ia.we && ia.abus == OUT_DEV_ADDR) out_dev <= dbus_a[9:0];
  end
  assign dbus_a = (!ia.we && ia.abus == OUT_DEV_ADDR) ? {22'd0, out_dev} : 32'hzzzz_zzzz;

  // Read-only input device on bus B holding a constant.
  assign dbus_b = (!ib.we && ib.abus == IN_DEV_ADDR) ? 32'h0000_0155 : 32'hzzzz_zzzz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ia.done != '0) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL a_unexpected_done: done=%b, expected no completion", ia.done);
      end else begin
        e = qa.pop_front();
        chk("a_done_onehot", 64'(ia.done), 64'(1) << e.idx);
        if (e.rd) chk("a_rdata", 64'(ia.rdata), 64'(e.rdata));
      end
    end
    if (!reset && ib.done != '0) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL b_unexpected_done: done=%b, expected no completion", ib.done);
      end else begin
        e = qb.pop_front();
        chk("b_done_onehot", 64'(ib.done), 64'(1) << e.idx);
        if (e.rd) chk("b_rdata", 64'(ib.rdata), 64'(e.rdata));
      end
    end
  end

  // One transaction on bus A; called at a negedge while the arbiter is idle.
  task automatic txn_a(input int i, input bit w, input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output int acc, output int bad);
    int c0;
    ia.req_we[i] = w;
    ia.req_addr[i*32 +: 32] = addr;
    ia.req_wdata[i*32 +: 32] = wd;
    ia.req[i] = 1'b1;
    c0 = cyc;
    lat = -1;
    acc = 0;
    bad = 0;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (ia.abus == addr && ia.we == w) acc++;
      if (ia.we && dbus_a !== wd) bad++;
      if (ia.done[i]) begin
        lat = cyc - c0;
        ia.req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc, bad, c0, n, gbad, n1, t1a, t1b, t0;
    int td[4];
    ia.req = '0; ia.req_we = '0; ia.req_addr = '0; ia.req_wdata = '0; ia.lock = '0;
    ib.req = '0; ib.req_we = '0; ib.req_addr = '0; ib.req_wdata = '0; ib.lock = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(ia.gnt), 64'd0);
    chk("rst_done", 64'(ia.done), 64'd0);
    chk("rst_abus", 64'(ia.abus), 64'(IDLE_ADDR_DEF));
    chk("rst_we", 64'(ia.we), 64'd0);
    chk("rst_rdata", 64'(ia.rdata), 64'd0);
    chk("rst_abus_b", 64'(ib.abus), 64'(IDLE_ADDR_DEF));
    reset = 1'b0;
    @(negedge clk);

    // Single write, no wait cycles.
    qa.push_back('{idx: 0, rd: 1'b0, rdata: 32'h0});
    txn_a(0, 1'b1, OUT_DEV_ADDR, 32'h3FF, lat, acc, bad);
    chk("wr_latency", 64'(lat), 64'd2);
    chk("wr_access_cycles", 64'(acc), 64'd1);
    chk("wr_dbus_data", 64'(bad), 64'd0);
    @(negedge clk);
    chk("wr_out_dev", 64'(out_dev), 64'h3FF);

    // Read back through requester 1.
    qa.push_back('{idx: 1, rd: 1'b1, rdata: 32'h3FF});
    txn_a(1, 1'b0, OUT_DEV_ADDR, 32'h0, lat, acc, bad);
    chk("rd_latency", 64'(lat), 64'd2);
    chk("rd_access_cycles", 64'(acc), 64'd1);
    @(negedge clk);

    // Read with two wait cycles on bus B.
    qb.push_back('{idx: 0, rd: 1'b1, rdata: 32'h155});
    ib.req_we[0] = 1'b0;
    ib.req_addr[31:0] = IN_DEV_ADDR;
    ib.req[0] = 1'b1;
    c0 = cyc; lat = -1; acc = 0; bad = 0;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (ib.abus == IN_DEV_ADDR) begin
        acc++;
        if (ib.we || dbus_b !== 32'h155) bad++;
      end
      if (ib.done[0]) begin
        lat = cyc - c0;
        ib.req[0] = 1'b0;
      end
    end
    chk("w2_latency", 64'(lat), 64'd4);
    chk("w2_access_cycles", 64'(acc), 64'd3);
    chk("w2_bus_read_only", 64'(bad), 64'd0);
    @(negedge clk);

    // Contention: both requesters held high; grants must alternate starting at 0.
    qa.push_back('{idx: 0, rd: 1'b1, rdata: 32'h3FF});
    qa.push_back('{idx: 1, rd: 1'b0, rdata: 32'h0});
    qa.push_back('{idx: 0, rd: 1'b1, rdata: 32'h0AA});
    qa.push_back('{idx: 1, rd: 1'b0, rdata: 32'h0});
    ia.req_we = 2'b10;
    ia.req_addr = {OUT_DEV_ADDR, OUT_DEV_ADDR};
    ia.req_wdata = {32'h0AA, 32'h0};
    ia.req = 2'b11;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (ia.done != '0) begin
        td[n] = cyc;
        n++;
        if (n == 4) ia.req = 2'b00;
      end
    end
    chk("rr_done_count", 64'(n), 64'd4);
    for (int k = 1; k < 4; k++) chk("rr_period", 64'(td[k] - td[k-1]), 64'd3);
    @(negedge clk);

    // Reset in the middle of a write ACCESS: bus parks immediately, no done.
    ia.req_we[0] = 1'b1;
    ia.req_addr[31:0] = OUT_DEV_ADDR;
    ia.req_wdata[31:0] = 32'h1C3;
    ia.req[0] = 1'b1;
    @(posedge clk);
    #1 chk("mid_access_abus", 64'(ia.abus), 64'(OUT_DEV_ADDR));
    #1 reset = 1'b1;
    #1;
    chk("arst_abus", 64'(ia.abus), 64'(IDLE_ADDR_DEF));
    chk("arst_we", 64'(ia.we), 64'd0);
    chk("arst_gnt", 64'(ia.gnt), 64'd0);
    ia.req[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_rdata", 64'(ia.rdata), 64'd0);
    qa.push_back('{idx: 1, rd: 1'b0, rdata: 32'h0});
    txn_a(1, 1'b1, OUT_DEV_ADDR, 32'h02A, lat, acc, bad);
    chk("post_rst_latency", 64'(lat), 64'd2);
    @(negedge clk);
    chk("post_rst_out_dev", 64'(out_dev), 64'h02A);

    // Requester 1 asks for a locked read-then-write while requester 0 waits.
`ifdef IOARB_LOCK_EN
    qa.push_back('{idx: 1, rd: 1'b1, rdata: 32'h02A});
    qa.push_back('{idx: 1, rd: 1'b0, rdata: 32'h0});
    qa.push_back('{idx: 0, rd: 1'b1, rdata: 32'h2C5});
`else
    qa.push_back('{idx: 1, rd: 1'b1, rdata: 32'h02A});
    qa.push_back('{idx: 0, rd: 1'b1, rdata: 32'h02A});
    qa.push_back('{idx: 1, rd: 1'b0, rdata: 32'h0});
`endif
    ia.req_we[1] = 1'b0;
    ia.req_addr[63:32] = OUT_DEV_ADDR;
    ia.lock[1] = 1'b1;
    ia.req[1] = 1'b1;
    @(negedge clk);
    ia.req_we[0] = 1'b0;
    ia.req_addr[31:0] = OUT_DEV_ADDR;
    ia.req[0] = 1'b1;
    n1 = 0; t1a = -1; t1b = -1; t0 = -1; gbad = 0;
    for (int k = 0; k < 30 && !(n1 == 2 && t0 >= 0); k++) begin
      @(negedge clk);
      if (n1 == 1 && ia.gnt != 2'b10) gbad++;
      if (ia.done[1]) begin
        if (n1 == 0) begin
          t1a = cyc;
          ia.req_we[1] = 1'b1;
          ia.req_wdata[63:32] = 32'h2C5;
          n1 = 1;
        end else begin
          t1b = cyc;
          ia.req[1] = 1'b0;
          ia.lock[1] = 1'b0;
          n1 = 2;
        end
      end
      if (ia.done[0]) begin
        t0 = cyc;
        ia.req[0] = 1'b0;
      end
    end
`ifdef IOARB_LOCK_EN
    chk("lock_period", 64'(t1b - t1a), 64'd2);
    chk("lock_gnt_held", 64'(gbad), 64'd0);
    chk("lock_then_req0", 64'(t0 > t1b), 64'd1);
`else
    chk("nolock_req0_between", 64'(t0 > t1a && t0 < t1b), 64'd1);
`endif
    repeat (3) @(negedge clk);
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
